serial_wide_adder: RTL and testbench
====================================

# serial_wide_adder

Nibble-serial wide adder that accepts WIDTH-bit operands over a valid/ready handshake and computes the sum one 4-bit slice per cycle. Each slice goes through a single instance of the codebase's combinational 4-bit prefix adder (`adder`), with its carry-out registered and fed back as the next slice's carry-in. It sits directly upstream of that adder, driving its `a`, `b` and `cin` and consuming its `sum` and `cout`. It lets one small prefix adder serve datapaths wider than 4 bits at a throughput of one result per WIDTH/4+1 cycles.

## Interface
- WIDTH, 16, operand/result width in bits. Legal values: multiple of 4, range 4..64.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  in_a + in_b + in_cin, mod 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: waiting for operands.
  - RUN: processing slices.
  - DONE: holding the result.
- Internal registers:
  - opa_sr, opb_sr: WIDTH-bit operand shift registers.
  - res_sr: WIDTH-bit result shift register.
  - carry_q: 1-bit carry register.
  - cnt: slice counter, $clog2(WIDTH/4)+1 bits wide.
- Adder hookup: `a` = opa_sr[3:0], `b` = opb_sr[3:0], `cin` = carry_q.
- in_ready = rst_n & ((state==IDLE) | (state==DONE & out_ready)).
- Accept (in_valid & in_ready):
  - Load opa_sr=in_a, opb_sr=in_b, carry_q=in_cin, cnt=0.
  - Go to RUN.
  - Input values outside an accept cycle are ignored.
- RUN, each cycle:
  - opa_sr, opb_sr shift right by 4 bits, zero-filled.
  - res_sr = {adder.sum, res_sr[WIDTH-1:4]}.
  - carry_q = adder.cout; cnt += 1.
- Leaving RUN: on the cycle where cnt == WIDTH/4-1:
  - Next state is DONE.
  - out_sum is loaded with {adder.sum, res_sr[WIDTH-1:4]}.
  - out_cout is loaded with adder.cout.
- DONE:
  - out_valid=1. out_sum and out_cout are held stable until out_valid & out_ready.
  - On handshake with in_valid=1, accept new operands in the same cycle and go to RUN (back-to-back).
  - On handshake with in_valid=0, go to IDLE.
- out_sum and out_cout change only on entry to DONE. They keep their last value in IDLE and RUN.
- Arithmetic is unsigned. Overflow appears only on out_cout; out_sum wraps mod 2^WIDTH.
- WIDTH=4: RUN lasts exactly one cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, out_valid=0, out_sum=0, out_cout=0, in_ready=0.
  - All internal registers are cleared.
- First rising edge after rst_n deasserts: in_ready=1.
- Latency: acceptance at edge E gives out_valid=1 after edge E+WIDTH/4 (4 cycles for WIDTH=16).
- Throughput: one result per WIDTH/4+1 cycles under continuous valid/ready.
- out_valid is a registered output; it never depends combinationally on out_ready.
- in_ready depends combinationally on out_ready in DONE only.
- Reset asserted in RUN or DONE:
  - The in-flight operation is discarded and no result is produced.
  - Outputs take reset values immediately, without waiting for clk.
- in_valid during RUN is not accepted (in_ready=0). The upstream must hold its request.
- out_ready during IDLE or RUN has no effect.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=1 → out_sum=0x5556, out_cout=0, out_valid rises 4 cycles after accept.
- WIDTH=16, a=0xFFFF, b=0x0000, cin=1 → out_sum=0x0000, out_cout=1. This checks carry propagation across all 4 slices via carry_q.
- Backpressure: a=0x8000, b=0x8000, cin=0, out_ready held low 5 cycles → out_sum=0x0000 and out_cout=1 held, out_valid=1, in_ready=0 throughout. Result drains on the cycle out_ready=1.
- Back-to-back: in_valid held high with 3 operand sets, out_ready=1 → one result every 5 cycles, in order, no lost or duplicated results.
- Reset mid-RUN: assert rst_n low 2 cycles after accept → out_valid=0, out_sum=0 immediately. After release, 0x0001+0x0001 cin=0 yields 0x0002 with normal latency.
- WIDTH=4 and WIDTH=64: 1000 random operands with random out_ready stalls, compared against a behavioural a+b+cin model, zero mismatches.

Source files
------------

// File: rtl/serial_wide_adder.sv
// Nibble-serial wide adder: one 4-bit prefix adder processes the operands one slice per
// cycle, with the slice carry held in a register between cycles.

module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g, p;
    logic       g10, p10, g32, p32, g30, p30;
    logic       c1, c2, c3;

    assign g = a & b;
    assign p = a ^ b;

    // Two-level prefix tree of (generate, propagate) pairs
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g10 | (p10 & cin);
    assign c3   = g[2] | (p[2] & c2);
    assign cout = g30 | (p30 & cin);
    assign sum  = p ^ {c3, c2, c1, cin};
endmodule

module serial_wide_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int SLICES = WIDTH / 4;
    localparam int CW     = $clog2(SLICES) + 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa_sr, opb_sr, res_sr, res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [3:0]       add_sum;
    logic             add_cout;

    adder u_adder (
        .a    (opa_sr[3:0]),
        .b    (opb_sr[3:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // New slice enters at the top; after SLICES shifts slice 0 sits at bit 0
    assign res_next = (res_sr >> 4) | (WIDTH'(add_sum) << (WIDTH - 4));

    assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa_sr    <= '0;
            opb_sr    <= '0;
            res_sr    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa_sr  <= in_a;
                        opb_sr  <= in_b;
                        carry_q <= in_cin;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    opa_sr  <= opa_sr >> 4;
                    opb_sr  <= opb_sr >> 4;
                    res_sr  <= res_next;
                    carry_q <= add_cout;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_sum   <= res_next;
                        out_cout  <= add_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            opa_sr  <= in_a;
                            opb_sr  <= in_b;
                            carry_q <= in_cin;
                            cnt     <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_wide_adder.sv
// Bench for serial_wide_adder: directed WIDTH=16 scenarios, then randomized traffic with
// stalls on WIDTH=16, 4 and 64 instances, scored against plain a+b+cin arithmetic.

module tb_serial_wide_adder;
    logic clk, rst_n;
    int   checks = 0;
    int   failures = 0;

    // Shared stimulus, steered to the instance selected by sel
    int          sel = 16;
    logic        c_in_valid, c_in_cin, c_out_ready;
    logic [63:0] c_in_a, c_in_b;

    logic        o_valid, o_ready, o_cout;
    logic [63:0] o_sum;

    logic        r16, v16, k16;
    logic [15:0] s16;
    logic        r4, v4, k4;
    logic [3:0]  s4;
    logic        r64, v64, k64;
    logic [63:0] s64;

    serial_wide_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid && sel == 16), .in_ready(r16),
        .in_a(c_in_a[15:0]), .in_b(c_in_b[15:0]), .in_cin(c_in_cin),
        .out_valid(v16), .out_ready(c_out_ready), .out_sum(s16), .out_cout(k16)
    );
    serial_wide_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid && sel == 4), .in_ready(r4),
        .in_a(c_in_a[3:0]), .in_b(c_in_b[3:0]), .in_cin(c_in_cin),
        .out_valid(v4), .out_ready(c_out_ready), .out_sum(s4), .out_cout(k4)
    );
    serial_wide_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid && sel == 64), .in_ready(r64),
        .in_a(c_in_a), .in_b(c_in_b), .in_cin(c_in_cin),
        .out_valid(v64), .out_ready(c_out_ready), .out_sum(s64), .out_cout(k64)
    );

    always_comb begin
        o_valid = v16; o_ready = r16; o_sum = {48'd0, s16}; o_cout = k16;
        if (sel == 4) begin
            o_valid = v4; o_ready = r4; o_sum = {60'd0, s4}; o_cout = k4;
        end else if (sel == 64) begin
            o_valid = v64; o_ready = r64; o_sum = s64; o_cout = k64;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: {cout, sum} of an unsigned w-bit add, returned as cout<<64 | sum
    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input int w);
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        return {full[w], full[63:0] & wmask(w)};
    endfunction

    // Entered and left at posedge+1; single operation with out_ready held high
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic ci,
                         input logic [63:0] es, input logic ec, input string tag);
        int n;
        c_in_a = a; c_in_b = b; c_in_cin = ci; c_in_valid = 1'b1; c_out_ready = 1'b1;
        chk({tag, "_in_ready"}, o_ready, 1);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_sum"}, o_sum, es);
        chk({tag, "_cout"}, o_cout, ec);
        @(posedge clk); #1;
        chk({tag, "_drained"}, o_valid, 0);
    endtask

    task automatic run_random(input int w, input int nops);
        logic [64:0] q[$];
        logic [64:0] exp;
        int sent, got, guard;
        logic acc;
        sel = w;
        sent = 0; got = 0; guard = 0; acc = 1'b0;
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        while (got < nops && guard < nops * 40 + 1000) begin
            @(posedge clk); #1;
            if (!c_in_valid || acc) begin
                if (sent < nops && ($urandom % 4) != 0) begin
                    c_in_a = {$urandom, $urandom} & wmask(w);
                    c_in_b = {$urandom, $urandom} & wmask(w);
                    if (($urandom % 8) == 0) c_in_a = wmask(w);
                    c_in_cin = 1'($urandom);
                    c_in_valid = 1'b1;
                end else begin
                    c_in_valid = 1'b0;
                end
            end
            c_out_ready = (($urandom % 4) != 0);
            @(negedge clk);
            acc = c_in_valid && o_ready;
            if (acc) begin
                q.push_back(ref_add(c_in_a, c_in_b, c_in_cin, w));
                sent++;
            end
            if (o_valid && c_out_ready) begin
                if (q.size() == 0) begin
                    chk($sformatf("w%0d_spurious", w), {o_cout, o_sum}, 65'd0 - 65'd1);
                end else begin
                    exp = q.pop_front();
                    chk($sformatf("w%0d_result%0d", w, got), {o_cout, o_sum}, exp);
                end
                got++;
            end
            guard++;
        end
        @(posedge clk); #1;
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        chk($sformatf("w%0d_count", w), got, nops);
        chk($sformatf("w%0d_queue_empty", w), q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("w%0d_idle", w), o_valid, 0);
    endtask

    logic [63:0] bb_a[3] = '{64'h0F0F, 64'hABCD, 64'h7FFF};
    logic [63:0] bb_b[3] = '{64'h00F1, 64'h5432, 64'h0001};
    logic        bb_c[3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] bb_s[3] = '{64'h1000, 64'h0000, 64'h8000};
    logic        bb_k[3] = '{1'b0, 1'b1, 1'b0};
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int n, t, tprev;
        rst_n = 1'b0;
        c_in_valid = 1'b0; c_in_cin = 1'b0; c_out_ready = 1'b0;
        c_in_a = '0; c_in_b = '0;
        #2;
        chk("rst_out_valid", o_valid, 0);
        chk("rst_out_sum", o_sum, 0);
        chk("rst_out_cout", o_cout, 0);
        chk("rst_in_ready", o_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", o_ready, 1);

        do_op(64'h1234, 64'h4321, 1'b1, 64'h5556, 1'b0, "basic");
        do_op(64'hFFFF, 64'h0000, 1'b1, 64'h0000, 1'b1, "carry_chain");

        // Backpressure: result must sit still while out_ready is low
        c_in_a = 64'h8000; c_in_b = 64'h8000; c_in_cin = 1'b0;
        c_in_valid = 1'b1; c_out_ready = 1'b0;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), o_valid, 1);
            chk($sformatf("bp_sum%0d", i), o_sum, 64'h0);
            chk($sformatf("bp_cout%0d", i), o_cout, 1);
            chk($sformatf("bp_in_ready%0d", i), o_ready, 0);
            @(posedge clk); #1;
        end
        c_out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", o_ready, 1);
        @(posedge clk); #1;
        chk("bp_drained", o_valid, 0);

        // Back-to-back: in_valid stays high, each new set taken on the drain edge
        c_in_a = bb_a[0]; c_in_b = bb_b[0]; c_in_cin = bb_c[0]; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_a = bb_a[1]; c_in_b = bb_b[1]; c_in_cin = bb_c[1];
        tprev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!o_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            t = cyc;
            chk($sformatf("b2b_sum%0d", k), o_sum, bb_s[k]);
            chk($sformatf("b2b_cout%0d", k), o_cout, bb_k[k]);
            if (k > 0) chk($sformatf("b2b_period%0d", k), t - tprev, 5);
            tprev = t;
            @(posedge clk); #1;
            if (k == 0) begin
                c_in_a = bb_a[2]; c_in_b = bb_b[2]; c_in_cin = bb_c[2];
            end else begin
                c_in_valid = 1'b0;
            end
        end
        chk("b2b_idle", o_valid, 0);

        // Asynchronous reset in the middle of a run
        c_in_a = 64'h1111; c_in_b = 64'h2222; c_in_cin = 1'b0; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", o_valid, 0);
        chk("midrst_out_sum", o_sum, 0);
        chk("midrst_in_ready", o_ready, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_result", o_valid, 0);
        do_op(64'h0001, 64'h0001, 1'b0, 64'h0002, 1'b0, "after_rst");

        run_random(16, 200);
        run_random(4, 1000);
        run_random(64, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
